// File: rtl/seg7_scan_driver.sv
// Eight-digit common-anode 7-segment scanner with frame-synchronous update of the
// displayed value and optional leading-zero blanking.
module seg7_scan_driver #(
  parameter int DIV   = 50000,
  parameter int DIV_W = 16
) (
  input  logic        base_clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_dp,
  input  logic        blank_lz,
  output logic [7:0]  o_seg,
  output logic [7:0]  o_sel,
  output logic        frame_done
);

  function automatic logic [6:0] seg_lut(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      disp_data_q, disp_data_d;
  logic [7:0]       disp_dp_q, disp_dp_d;
  logic [31:0]      pend_data_q, pend_data_d;
  logic [7:0]       pend_dp_q, pend_dp_d;
  logic             pend_v_q, pend_v_d;
  logic             wrap_q, wrap_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       sel_q, sel_d;
  logic             frame_done_q, frame_done_d;

  logic             tick;
  logic             boundary;
  logic [3:0]       nib;
  logic [31:0]      upper;
  logic             blank;

  always_comb begin
    tick         = (div_q == DIV_W'(DIV - 1));
    boundary     = tick && (idx_q == 3'd7);
    div_d        = tick ? '0 : div_q + DIV_W'(1);
    idx_d        = tick ? idx_q + 3'd1 : idx_q;
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_v_d     = pend_v_q;

    // disp only moves on the 7->0 wrap; a write landing on that cycle wins over pend
    if (boundary) begin
      pend_v_d = 1'b0;
      if (wr_en) begin
        disp_data_d = wr_data;
        disp_dp_d   = wr_dp;
      end else if (pend_v_q) begin
        disp_data_d = pend_data_q;
        disp_dp_d   = pend_dp_q;
      end
    end else if (wr_en) begin
      pend_data_d = wr_data;
      pend_dp_d   = wr_dp;
      pend_v_d    = 1'b1;
    end

    // wrap_q delays the pulse one cycle so it lines up with digit 0 on o_sel
    wrap_d       = boundary;
    frame_done_d = wrap_q;

    nib   = disp_data_q[{idx_q, 2'b00} +: 4];
    upper = disp_data_q >> {idx_q, 2'b00};
    blank = blank_lz && (idx_q != 3'd0) && (upper == 32'd0);

    if (blank) begin
      sel_d = 8'hFF;
      seg_d = 8'hFF;
    end else begin
      sel_d = ~(8'd1 << idx_q);
      seg_d = {~disp_dp_q[idx_q], seg_lut(nib)};
    end
  end

  always_ff @(posedge base_clk) begin
    if (reset) begin
      div_q        <= '0;
      idx_q        <= 3'd0;
      disp_data_q  <= 32'd0;
      disp_dp_q    <= 8'd0;
      pend_data_q  <= 32'd0;
      pend_dp_q    <= 8'd0;
      pend_v_q     <= 1'b0;
      wrap_q       <= 1'b0;
      seg_q        <= 8'hFF;
      sel_q        <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_v_q     <= pend_v_d;
      wrap_q       <= wrap_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_seg      = seg_q;
  assign o_sel      = sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a DIV=4 instance checked frame by frame against an
// expected queue, plus a DIV=1 instance checked for per-cycle rotation.
module tb_seg7_scan_driver;

  logic        base_clk = 1'b0;
  logic        reset    = 1'b1;
  logic        wr_en    = 1'b0;
  logic [31:0] wr_data  = 32'd0;
  logic [7:0]  wr_dp    = 8'd0;
  logic        blank_lz = 1'b0;

  logic [7:0]  seg4, sel4, seg1, sel1;
  logic        fd4, fd1;

  int checks = 0;
  int errors = 0;

  // one entry per digit of a frame: {o_sel, o_seg}, digit 0 first
  logic [15:0] exp_q[$];

  always #5 base_clk = ~base_clk;

  seg7_scan_driver #(.DIV(4), .DIV_W(3)) u_dut4 (
    .base_clk(base_clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .wr_dp(wr_dp), .blank_lz(blank_lz), .o_seg(seg4), .o_sel(sel4),
    .frame_done(fd4)
  );

  seg7_scan_driver #(.DIV(1), .DIV_W(1)) u_dut1 (
    .base_clk(base_clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .wr_dp(wr_dp), .blank_lz(blank_lz), .o_seg(seg1), .o_sel(sel1),
    .frame_done(fd1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // segs byte k = expected o_seg of digit k; lit bit k = digit k selected
  task automatic push_frame(input logic [63:0] segs, input logic [7:0] lit);
    logic [7:0] sel;
    for (int k = 0; k < 8; k++) begin
      sel = lit[k] ? ~(8'd1 << k) : 8'hFF;
      exp_q.push_back({sel, segs[8*k +: 8]});
    end
  endtask

  task automatic wait_frame(output int cyc);
    cyc = 0;
    do begin
      @(negedge base_clk);
      cyc++;
    end while (fd4 !== 1'b1 && cyc < 100);
    if (fd4 !== 1'b1) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic write(input logic [31:0] d, input logic [7:0] dp);
    wr_en   = 1'b1;
    wr_data = d;
    wr_dp   = dp;
    @(negedge base_clk);
    wr_en   = 1'b0;
  endtask

  // monitor: each frame_done pulse starts a frame; pop its 8 digits if queued
  initial begin
    logic [15:0] cur [8];
    bit act = 0;
    int ph  = 0;
    forever begin
      @(negedge base_clk);
      if (fd4 === 1'b1 && !act && exp_q.size() >= 8) begin
        for (int k = 0; k < 8; k++) cur[k] = exp_q.pop_front();
        act = 1;
        ph  = 0;
      end
      if (act) begin
        chk($sformatf("digit%0d_ph%0d", ph / 4, ph % 4), {16'd0, sel4, seg4}, {16'd0, cur[ph / 4]});
        chk("frame_done_pos", {31'd0, fd4}, {31'd0, (ph == 0)});
        ph++;
        if (ph == 32) act = 0;
      end
    end
  end

  // DIV=1 instance: rotates every cycle, frame_done every 8 cycles
  initial begin
    wait (reset == 1'b0);
    @(posedge base_clk);
    #1;
    for (int i = 0; i < 24; i++) begin
      chk("div1_sel", {24'd0, sel1}, {24'd0, ~(8'd1 << (i % 8))});
      chk("div1_seg", {24'd0, seg1}, 32'hC0);
      chk("div1_fd", {31'd0, fd1}, {31'd0, (i == 8 || i == 16)});
      @(posedge base_clk);
      #1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;

    // reset and first frame
    repeat (3) @(negedge base_clk);
    chk("rst_sel", {24'd0, sel4}, 32'hFF);
    chk("rst_seg", {24'd0, seg4}, 32'hFF);
    chk("rst_fd", {31'd0, fd4}, 32'd0);
    reset = 1'b0;
    @(negedge base_clk);
    chk("rel_sel", {24'd0, sel4}, 32'hFE);
    chk("rel_seg", {24'd0, seg4}, 32'hC0);
    chk("rel_fd", {31'd0, fd4}, 32'd0);
    push_frame(64'hC0C0C0C0_C0C0C0C0, 8'hFF);
    wait_frame(cyc);
    @(negedge base_clk);
    push_frame(64'hC0C0C0C0_C0C0C0C0, 8'hFF);
    wait_frame(cyc);
    chk("frame_period", cyc, 32'd31);

    // mid-frame write only appears in the next frame
    @(negedge base_clk);
    repeat (5) @(negedge base_clk);
    write(32'h89ABCDEF, 8'h01);
    push_frame(64'h80908883_C6A1860E, 8'hFF);
    wait_frame(cyc);
    chk("frame_period2", cyc, 32'd25);

    // two writes in one frame: last wins
    @(negedge base_clk);
    repeat (3) @(negedge base_clk);
    write(32'h1, 8'h00);
    repeat (3) @(negedge base_clk);
    write(32'h2, 8'h00);
    push_frame(64'hC0C0C0C0_C0C0C0A4, 8'hFF);
    wait_frame(cyc);

    // pending write overridden by a write on the boundary cycle (c+30)
    @(negedge base_clk);
    repeat (4) @(negedge base_clk);
    write(32'h7, 8'h00);
    push_frame(64'hC0C0C0C0_C0C0C0B0, 8'hFF);
    repeat (24) @(negedge base_clk);
    write(32'h3, 8'h00);
    wait_frame(cyc);
    chk("boundary_frame_len", cyc, 32'd1);
    @(negedge base_clk);
    push_frame(64'hC0C0C0C0_C0C0C0B0, 8'hFF);
    wait_frame(cyc);

    // leading-zero blanking, dp suppressed on blanked digits
    @(negedge base_clk);
    repeat (4) @(negedge base_clk);
    write(32'h00000305, 8'h08);
    push_frame(64'hFFFFFFFF_FFB0C092, 8'h07);
    wait_frame(cyc);
    blank_lz = 1'b1;
    @(negedge base_clk);
    repeat (4) @(negedge base_clk);
    write(32'h0, 8'h02);
    push_frame(64'hFFFFFFFF_FFFFFFC0, 8'h01);
    wait_frame(cyc);
    wait_frame(cyc);

    // reset mid-frame drops the pending write
    @(negedge base_clk);
    blank_lz = 1'b0;
    repeat (4) @(negedge base_clk);
    write(32'hFFFFFFFF, 8'hFF);
    repeat (3) @(negedge base_clk);
    reset = 1'b1;
    @(posedge base_clk);
    #1;
    chk("rst2_sel", {24'd0, sel4}, 32'hFF);
    chk("rst2_seg", {24'd0, seg4}, 32'hFF);
    chk("rst2_fd", {31'd0, fd4}, 32'd0);
    @(negedge base_clk);
    reset = 1'b0;
    @(posedge base_clk);
    #1;
    chk("rel2_sel", {24'd0, sel4}, 32'hFE);
    chk("rel2_seg", {24'd0, seg4}, 32'hC0);
    @(negedge base_clk);
    push_frame(64'hC0C0C0C0_C0C0C0C0, 8'hFF);
    wait_frame(cyc);
    @(negedge base_clk);
    wait_frame(cyc);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
